// File: rtl/axi4_lite_rr_master.sv
// rtl/axi4_lite_rr_master.sv - two-requester round-robin arbiter and AXI4-Lite master sequencer
// One command at a time is granted and driven through AW/W/B or AR/R; all AXI outputs come from flops.
module axi4_lite_rr_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [1:0]        resp0,
  output logic [1:0]        resp1,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY
);

  typedef enum logic [2:0] {IDLE, WA, WB, RA, RD, DONE} state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [1:0]        resp0_q, resp0_d;
  logic [1:0]        resp1_q, resp1_d;

  logic sel;
  logic aw_hs;
  logic w_hs;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    resp0_d   = resp0_q;
    resp1_d   = resp1_q;
    // With both requesting the rr pointer decides; otherwise whoever is asking wins.
    sel   = (req0 && req1) ? rr_q : req1;
    aw_hs = awvalid_q && AWREADY;
    w_hs  = wvalid_q && WREADY;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = sel;
          addr_d  = sel ? addr1 : addr0;
          wdata_d = sel ? wdata1 : wdata0;
          if (sel ? we1 : we0) begin
            state_d   = WA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RA;
            arvalid_d = 1'b1;
          end
        end
      end
      WA: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d  = WB;
          bready_d = 1'b1;
        end
      end
      WB: begin
        if (BVALID && bready_q) begin
          bready_d = 1'b0;
          state_d  = DONE;
          if (gnt_q) begin
            resp1_d = BRESP;
            done1_d = 1'b1;
          end else begin
            resp0_d = BRESP;
            done0_d = 1'b1;
          end
        end
      end
      RA: begin
        if (arvalid_q && ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD;
        end
      end
      RD: begin
        if (RVALID && rready_q) begin
          rready_d = 1'b0;
          state_d  = DONE;
          if (gnt_q) begin
            rdata1_d = RDATA;
            resp1_d  = RRESP;
            done1_d  = 1'b1;
          end else begin
            rdata0_d = RDATA;
            resp0_d  = RRESP;
            done0_d  = 1'b1;
          end
        end
      end
      DONE: begin
        rr_d    = ~gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      gnt_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      resp0_q   <= 2'b00;
      resp1_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      resp0_q   <= resp0_d;
      resp1_q   <= resp1_d;
    end
  end

  assign AWADDR  = addr_q;
  assign ARADDR  = addr_q;
  assign WDATA   = wdata_q;
  assign AWVALID = awvalid_q;
  assign WVALID  = wvalid_q;
  assign BREADY  = bready_q;
  assign ARVALID = arvalid_q;
  assign RREADY  = rready_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign resp0   = resp0_q;
  assign resp1   = resp1_q;

endmodule

// File: tb/tb_axi4_lite_rr_master.sv
// tb/tb_axi4_lite_rr_master.sv - randomized bench with a 4-register slave and a grant/data reference model
module tb_axi4_lite_rr_master;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        req0, req1, we0, we1;
  logic [3:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        done0, done1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  resp0, resp1;
  logic [3:0]  AWADDR, ARADDR;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [1:0]  BRESP, RRESP;

  axi4_lite_rr_master #(.ADDR_W(4), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .resp0(resp0), .resp1(resp1),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Slave knobs: forced delays or random ones, optional random response codes.
  bit          k_force = 0;
  bit          k_rand_resp = 0;
  int          k_aw = 0, k_w = 0, k_b = 0, k_ar = 0, k_r = 0;
  logic [31:0] mem [4];
  int          s_wr_cnt = 0;
  logic [3:0]  s_waddr, s_raddr;
  logic [31:0] s_wdata;
  logic [1:0]  s_resp;

  task automatic slave_idle();
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
  endtask

  function automatic int dly(input int forced);
    return k_force ? forced : int'($urandom_range(0, 3));
  endfunction

  task automatic slave_write();
    int c = 0;
    int aw_d = dly(k_aw), w_d = dly(k_w), b_d = dly(k_b);
    bit aw_got = 0, w_got = 0, aw_hs, w_hs;
    logic [3:0] a = '0;
    logic [31:0] d = '0;
    while (!(aw_got && w_got)) begin
      AWREADY = !aw_got && (c >= aw_d);
      WREADY  = !w_got && (c >= w_d);
      aw_hs = AWREADY && AWVALID;
      w_hs  = WREADY && WVALID;
      if (aw_hs) a = AWADDR;
      if (w_hs) d = WDATA;
      @(negedge ACLK);
      c++;
      if (!ARESETn) begin slave_idle(); return; end
      if (aw_hs) begin aw_got = 1; check_eq("awvalid_drop", 32'(AWVALID), 0); end
      else if (!aw_got) check_eq("awvalid_hold", 32'(AWVALID), 1);
      if (w_hs) begin w_got = 1; check_eq("wvalid_drop", 32'(WVALID), 0); end
      else if (!w_got) check_eq("wvalid_hold", 32'(WVALID), 1);
      if (c > 300) begin check_eq("slave_wr_timeout", 32'(c), 0); slave_idle(); return; end
    end
    AWREADY = 0; WREADY = 0;
    check_eq("bready_rise", 32'(BREADY), 1);
    mem[a[3:2]] = d;
    s_wr_cnt++; s_waddr = a; s_wdata = d;
    repeat (b_d) begin
      @(negedge ACLK);
      if (!ARESETn) begin slave_idle(); return; end
      check_eq("bready_hold", 32'(BREADY), 1);
      check_eq("early_done_w", 32'(done0 || done1), 0);
    end
    s_resp = k_rand_resp ? 2'($urandom_range(0, 3)) : 2'b00;
    BRESP = s_resp; BVALID = 1;
    @(negedge ACLK);
    slave_idle();
    if (ARESETn) check_eq("bready_drop", 32'(BREADY), 0);
  endtask

  task automatic slave_read();
    int c = 0;
    int ar_d = dly(k_ar), r_d = dly(k_r);
    bit hs;
    logic [3:0] a = '0;
    forever begin
      ARREADY = (c >= ar_d);
      hs = ARREADY && ARVALID;
      if (hs) a = ARADDR;
      @(negedge ACLK);
      c++;
      if (!ARESETn) begin slave_idle(); return; end
      if (hs) begin
        check_eq("arvalid_drop", 32'(ARVALID), 0);
        check_eq("rready_rise", 32'(RREADY), 1);
        break;
      end
      check_eq("arvalid_hold", 32'(ARVALID), 1);
      if (c > 300) begin check_eq("slave_rd_timeout", 32'(c), 0); slave_idle(); return; end
    end
    ARREADY = 0;
    s_raddr = a;
    repeat (r_d) begin
      @(negedge ACLK);
      if (!ARESETn) begin slave_idle(); return; end
      check_eq("rready_hold", 32'(RREADY), 1);
      check_eq("early_done_r", 32'(done0 || done1), 0);
    end
    s_resp = k_rand_resp ? 2'($urandom_range(0, 3)) : 2'b00;
    RDATA = mem[a[3:2]]; RRESP = s_resp; RVALID = 1;
    @(negedge ACLK);
    slave_idle();
    if (ARESETn) check_eq("rready_drop", 32'(RREADY), 0);
  endtask

  initial begin : slave
    slave_idle();
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        for (int i = 0; i < 4; i++) mem[i] = '0;
        continue;
      end
      if (AWVALID || WVALID) slave_write();
      else if (ARVALID) slave_read();
    end
  end

  // Reference model: grant rule applied to the requests seen at each decision point,
  // a register array updated in completion order, and per-port held read/response values.
  typedef struct { int port; bit we; logic [3:0] addr; logic [31:0] data; } exp_t;
  exp_t        exp_q [$];
  int          rr_model = 0;
  int          ref_wr = 0;
  logic [31:0] ref_mem [4];
  logic [31:0] exp_rdata [2];
  logic [1:0]  exp_resp [2];

  initial begin : monitor
    exp_t e;
    bit prev_busy = 0, prev_r0 = 0, prev_r1 = 0, prev_d0 = 0, prev_d1 = 0, busy;
    bit p_we [2];
    logic [3:0] p_addr [2];
    logic [31:0] p_data [2];
    int g, p;
    forever begin
      @(negedge ACLK);
      #1;
      if (!ARESETn) begin
        exp_q.delete();
        rr_model = 0;
        for (int i = 0; i < 4; i++) ref_mem[i] = '0;
        for (int i = 0; i < 2; i++) begin exp_rdata[i] = '0; exp_resp[i] = '0; end
        prev_busy = 0; prev_r0 = 0; prev_r1 = 0; prev_d0 = 0; prev_d1 = 0;
        continue;
      end
      busy = AWVALID || WVALID || ARVALID || BREADY || RREADY || done0 || done1;
      if (!prev_busy && (prev_r0 || prev_r1))
        check_eq("grant_latency", 32'(AWVALID || ARVALID), 1);
      if ((AWVALID || ARVALID) && !prev_busy) begin
        check_eq("spurious_grant", 32'(prev_r0 || prev_r1), 1);
        g = (prev_r0 && prev_r1) ? rr_model : (prev_r1 ? 1 : 0);
        e.port = g; e.we = p_we[g]; e.addr = p_addr[g]; e.data = p_data[g];
        check_eq("start_kind", 32'(AWVALID), 32'(e.we));
        check_eq("start_valid_pair", 32'(WVALID), 32'(e.we));
        if (e.we) begin
          check_eq("awaddr", 32'(AWADDR), 32'(e.addr));
          check_eq("wdata", WDATA, e.data);
        end else
          check_eq("araddr", 32'(ARADDR), 32'(e.addr));
        exp_q.push_back(e);
      end
      if (prev_d0) check_eq("done0_width", 32'(done0), 0);
      if (prev_d1) check_eq("done1_width", 32'(done1), 0);
      if (done0 || done1) begin
        check_eq("done_excl", 32'(done0 && done1), 0);
        p = done1 ? 1 : 0;
        if (exp_q.size() == 0) check_eq("done_expected", 32'(exp_q.size()), 1);
        else begin
          e = exp_q.pop_front();
          check_eq("grant_order", 32'(p), 32'(e.port));
          if (e.we) begin
            ref_mem[e.addr[3:2]] = e.data;
            ref_wr++;
            check_eq("slave_wr_count", 32'(s_wr_cnt), 32'(ref_wr));
            check_eq("slave_waddr", 32'(s_waddr), 32'(e.addr));
            check_eq("slave_wdata", s_wdata, e.data);
          end else begin
            exp_rdata[p] = ref_mem[e.addr[3:2]];
            check_eq("slave_raddr", 32'(s_raddr), 32'(e.addr));
          end
          exp_resp[p] = s_resp;
          rr_model = 1 - p;
        end
        check_eq("rdata0", rdata0, exp_rdata[0]);
        check_eq("rdata1", rdata1, exp_rdata[1]);
        check_eq("resp0", 32'(resp0), 32'(exp_resp[0]));
        check_eq("resp1", 32'(resp1), 32'(exp_resp[1]));
      end
      prev_busy = busy; prev_r0 = req0; prev_r1 = req1;
      prev_d0 = done0; prev_d1 = done1;
      p_we[0] = we0; p_addr[0] = addr0; p_data[0] = wdata0;
      p_we[1] = we1; p_addr[1] = addr1; p_data[1] = wdata1;
    end
  end

  task automatic do_cmd(input int p, input bit w, input logic [3:0] a, input logic [31:0] d,
                        input bit drop_early);
    int n = 0;
    if (p == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    else begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    forever begin
      @(negedge ACLK);
      if ((p == 0 && done0) || (p == 1 && done1)) break;
      n++;
      if (drop_early && n == 3) begin
        if (p == 0) req0 = 0; else req1 = 0;
      end
      if (n > 600) begin check_eq($sformatf("done%0d_timeout", p), 32'(n), 0); break; end
    end
    if (p == 0) req0 = 0; else req1 = 0;
  endtask

  task automatic rand_cmds(input int p, input int cnt, input bit gaps);
    for (int i = 0; i < cnt; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge ACLK);
      do_cmd(p, bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 0);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin : main
    int n;
    ARESETn = 0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (2) @(negedge ACLK);
    check_eq("rst_axi_valid", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 0);
    check_eq("rst_done", 32'({done0, done1}), 0);
    check_eq("rst_rdata0", rdata0, 0);
    check_eq("rst_rdata1", rdata1, 0);
    check_eq("rst_resp", 32'({resp0, resp1}), 0);
    check_eq("rst_addr", 32'({AWADDR, ARADDR}), 0);

    // Contention from reset, then continuous re-requests from both ports.
    fork
      begin do_cmd(0, 1, 4'h0, 32'h11111111, 0); rand_cmds(0, 3, 0); end
      begin do_cmd(1, 1, 4'h8, 32'h22222222, 0); rand_cmds(1, 3, 0); end
      begin repeat (2) @(negedge ACLK); ARESETn = 1; end
    join

    repeat (2) @(negedge ACLK);
    do_cmd(0, 1, 4'h4, 32'hDEADBEEF, 0);
    check_eq("single_write_resp0", 32'(resp0), 0);
    do_cmd(1, 0, 4'h4, 32'h0, 0);
    check_eq("readback_rdata1", rdata1, 32'hDEADBEEF);

    // Ready skew: W before AW, same cycle, AW before W; then response back-pressure.
    k_force = 1;
    k_aw = 3; k_w = 0; do_cmd(0, 1, 4'hC, 32'hA5A5_0001, 0);
    k_aw = 2; k_w = 2; do_cmd(1, 1, 4'h8, 32'hA5A5_0002, 0);
    k_aw = 0; k_w = 3; do_cmd(0, 1, 4'h1, 32'hA5A5_0003, 0);
    k_aw = 0; k_w = 0; k_b = 5; k_r = 4;
    do_cmd(1, 1, 4'h4, 32'h1234_5678, 0);
    do_cmd(0, 0, 4'h4, 32'h0, 0);
    check_eq("backpressure_rdata0", rdata0, 32'h1234_5678);
    k_b = 3; do_cmd(1, 0, 4'hC, 32'h0, 1);
    k_force = 0; k_b = 0; k_r = 0;

    // Randomized traffic with response codes and independent request gaps.
    k_rand_resp = 1;
    fork
      rand_cmds(0, 15, 1);
      rand_cmds(1, 15, 1);
    join
    k_rand_resp = 0;

    // Reset while a write sits in WA waiting for slow ready.
    k_force = 1; k_aw = 40; k_w = 40;
    @(negedge ACLK);
    req0 = 1; we0 = 1; addr0 = 4'h4; wdata0 = 32'hCAFE_0001;
    n = 0;
    while (!AWVALID && n < 10) begin @(negedge ACLK); n++; end
    check_eq("midrst_awvalid_seen", 32'(AWVALID), 1);
    @(negedge ACLK);
    #3 ARESETn = 0;
    #1;
    check_eq("midrst_axi_valid", 32'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 0);
    check_eq("midrst_axi_bus", 32'({AWADDR, ARADDR}), 0);
    check_eq("midrst_wdata", WDATA, 0);
    check_eq("midrst_rdata", rdata0 | rdata1, 0);
    check_eq("midrst_resp", 32'({resp0, resp1}), 0);
    req0 = 0;
    repeat (3) begin
      @(negedge ACLK);
      check_eq("midrst_no_done", 32'({done0, done1}), 0);
    end
    ARESETn = 1;
    k_force = 0; k_aw = 0; k_w = 0;
    do_cmd(1, 0, 4'hC, 32'h0, 0);
    check_eq("post_reset_rdata1", rdata1, 0);
    check_eq("post_reset_resp1", 32'(resp1), 0);

    repeat (3) @(negedge ACLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
